acc_drain: RTL and testbench

Result-drain controller sitting on the read side of the GEMM accumulator. It pops 128-bit rows from the four column-group accumulation buffers through their `rd_en`/`o_data`/`empty` interface. It serializes each row into four 32-bit word writes on a valid/ready memory write port, placing the C tile row-major at a programmable base address and row stride. It is the stage between the accumulator and the RISC-V data-memory write path.

---
 rtl/acc_drain_pkg.sv | 7 +
 rtl/acc_drain_word_serializer.sv | 34 +++
 rtl/acc_drain.sv | 99 +++++++++
 tb/tb_acc_drain.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/acc_drain_pkg.sv
// acc_drain_pkg: shared datapath widths and the drain FSM state encoding
package acc_drain_pkg;
  localparam int SUPER_SYS_COLS = 16;
  localparam int P_BITWIDTH = 32;
  localparam int ROW_W = 4 * P_BITWIDTH;
  typedef enum logic [2:0] {IDLE, WAIT, READ, CAPT, WRITE} drain_state_e;
endpackage

// File: rtl/acc_drain_word_serializer.sv
// word_serializer: holds one popped row and streams it as four words over valid/ready
module word_serializer
  import acc_drain_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [ROW_W-1:0]      i_data,
  input  logic                  i_active,
  input  logic                  i_ready,
  output logic                  o_req,
  output logic                  o_fire,
  output logic                  o_last,
  output logic [1:0]            o_k,
  output logic [P_BITWIDTH-1:0] o_word
);
  logic [ROW_W-1:0] r_hold;
  logic [1:0]       r_k;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_hold <= '0;
      r_k    <= '0;
    end else if (i_load) begin
      r_hold <= i_data;
      r_k    <= '0;
    end else if (o_fire) begin
      r_k    <= r_k + 2'd1;
    end
  assign o_req  = i_active;
  assign o_fire = i_active & i_ready;
  assign o_last = r_k == 2'd3;
  assign o_k    = r_k;
  assign o_word = i_active ? r_hold[{r_k, 5'd0} +: P_BITWIDTH] : '0;
endmodule

// File: rtl/acc_drain.sv
// acc_drain: pops accumulator rows buffer by buffer and writes them row-major as 32-bit beats
module acc_drain
  import acc_drain_pkg::*;
#(
  parameter int NUM_BUF  = SUPER_SYS_COLS / 4,
  parameter int ADDR_W   = 32,
  parameter int N_ROWS_W = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 base_addr,
  input  logic [ADDR_W-1:0]                 row_stride,
  input  logic [N_ROWS_W-1:0]               n_rows,
  input  logic [2:0]                        n_groups,
  output logic [NUM_BUF-1:0]                acc_rd_en,
  input  logic [NUM_BUF-1:0][ROW_W-1:0]     acc_o_data,
  input  logic [NUM_BUF-1:0]                acc_empty,
  output logic                              mem_req,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [P_BITWIDTH-1:0]             mem_wdata,
  input  logic                              mem_ready,
  output logic                              busy,
  output logic                              done
);
  localparam int GW = NUM_BUF > 1 ? $clog2(NUM_BUF) : 1;
  drain_state_e          r_state, w_next;
  logic [ADDR_W-1:0]     r_stride, r_row_addr;
  logic [N_ROWS_W-1:0]   r_rows, r_r;
  logic [2:0]            r_groups;
  logic [GW-1:0]         r_g;
  logic                  r_done;
  logic                  w_zero, w_req, w_fire, w_last, w_row_end, w_final;
  logic [1:0]            w_k;
  logic [P_BITWIDTH-1:0] w_word;
  assign w_zero    = n_rows == '0 || n_groups == '0;
  assign w_row_end = 3'(r_g) == r_groups - 3'd1;
  assign w_final   = w_row_end && r_r == r_rows - N_ROWS_W'(1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start && !w_zero ? WAIT : IDLE;
      WAIT:    w_next = acc_empty[r_g] ? WAIT : READ;
      READ:    w_next = CAPT;
      CAPT:    w_next = WRITE;
      WRITE:   w_next = !(w_fire && w_last) ? WRITE : w_final ? IDLE : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // The parameter latch only fires from IDLE, so a start during a drain is ignored.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_done     <= 1'b0;
      r_stride   <= '0;
      r_rows     <= '0;
      r_groups   <= '0;
      r_row_addr <= '0;
      r_g        <= '0;
      r_r        <= '0;
    end else begin
      r_done <= (r_state == IDLE && start && w_zero) || (w_fire && w_last && w_final);
      if (r_state == IDLE && start) begin
        r_stride   <= row_stride;
        r_rows     <= n_rows;
        r_groups   <= n_groups > 3'(NUM_BUF) ? 3'(NUM_BUF) : n_groups;
        r_row_addr <= base_addr;
        r_g        <= '0;
        r_r        <= '0;
      end else if (w_fire && w_last) begin
        r_g <= w_row_end ? '0 : r_g + GW'(1);
        if (w_row_end) begin
          r_r        <= r_r + N_ROWS_W'(1);
          r_row_addr <= r_row_addr + r_stride;
        end
      end
    end
  word_serializer u_ser (
    .clk      (clk),
    .rst      (rst),
    .i_load   (r_state == CAPT),
    .i_data   (acc_o_data[r_g]),
    .i_active (r_state == WRITE),
    .i_ready  (mem_ready),
    .o_req    (w_req),
    .o_fire   (w_fire),
    .o_last   (w_last),
    .o_k      (w_k),
    .o_word   (w_word)
  );
  assign acc_rd_en = r_state == READ ? NUM_BUF'(1) << r_g : '0;
  assign mem_req   = w_req;
  assign mem_addr  = w_req ? r_row_addr + ADDR_W'({r_g, w_k, 2'b00}) : '0;
  assign mem_wdata = w_word;
  assign busy      = r_state != IDLE;
  assign done      = r_done;
endmodule

// File: tb/tb_acc_drain.sv
// tb_acc_drain: table-driven drains checked against a row-major address/data reference model
module tb_acc_drain;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start;
  logic [31:0]      base_addr, row_stride;
  logic [4:0]       n_rows;
  logic [2:0]       n_groups;
  logic [3:0]       acc_rd_en;
  logic [3:0][127:0] acc_o_data;
  logic [3:0]       acc_empty;
  logic             mem_req;
  logic [31:0]      mem_addr, mem_wdata;
  logic             mem_ready, busy, done;
  always #5 clk = ~clk;
  acc_drain dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_stride(row_stride),
    .n_rows(n_rows), .n_groups(n_groups), .acc_rd_en(acc_rd_en), .acc_o_data(acc_o_data),
    .acc_empty(acc_empty), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done)
  );
  typedef struct {
    logic [31:0] base;
    logic [31:0] stride;
    int nr, ng, prob, stall_buf, stall;
    bit restart;
    int exp_beats, exp_pops, exp_busy1, exp_rd1, exp_req1;
  } tcase_t;
  tcase_t      tbl [8];
  logic [127:0] rows [4][16];
  int          head [4];
  logic [31:0] exp_a [$];
  logic [31:0] exp_d [$];
  int          errors = 0, checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run(input int id, input tcase_t t);
    int ng, beats, pops, bad, unstable, misorder, dones, busy_bad, busy1, rd1, req1, rel, rd2, pend, done_cyc;
    bit ended, stalled;
    logic [31:0] pa, pd;
    ng = t.ng > 4 ? 4 : t.ng;
    beats = 0; pops = 0; bad = 0; unstable = 0; misorder = 0; dones = 0; busy_bad = 0; busy1 = 0;
    rd1 = 0; req1 = 0; rel = -1; rd2 = -1; pend = -1; done_cyc = 0; ended = 0; stalled = 0; pa = 0; pd = 0;
    exp_a.delete();
    exp_d.delete();
    for (int b = 0; b < 4; b++) begin
      head[b] = 0;
      for (int r = 0; r < 16; r++) rows[b][r] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    for (int r = 0; r < t.nr; r++)
      for (int g = 0; g < ng; g++)
        for (int k = 0; k < 4; k++) begin
          exp_a.push_back(t.base + 32'(r) * t.stride + 32'(16 * g + 4 * k));
          exp_d.push_back(rows[g][r][32*k +: 32]);
        end
    @(posedge clk); #1;
    start = 1'b1; base_addr = t.base; row_stride = t.stride;
    n_rows = 5'(t.nr); n_groups = 3'(t.ng); mem_ready = 1'b1;
    for (int cyc = 1; cyc <= 3000 && !ended; cyc++) begin
      @(posedge clk); #1;
      start = t.restart && cyc == 5;
      if (t.restart && cyc == 5) begin
        base_addr = 32'hDEAD0000; row_stride = 32'h4; n_rows = 5'd1; n_groups = 3'd1;
      end
      if (pend >= 0) begin
        acc_o_data[pend] = rows[pend][head[pend]-1];
        pend = -1;
      end
      for (int b = 0; b < 4; b++) acc_empty[b] = head[b] >= t.nr || (b == t.stall_buf && cyc <= t.stall);
      if (t.stall_buf >= 0 && cyc == t.stall + 1) rel = cyc;
      mem_ready = $urandom_range(99) < t.prob;
      #1;
      if (cyc == 1) busy1 = int'(busy);
      if (acc_rd_en != 4'd0) begin
        pops++;
        if ($countones(acc_rd_en) != 1 || beats != 4 * (pops - 1)) misorder++;
        if (rd1 == 0) rd1 = cyc;
        for (int b = 0; b < 4; b++)
          if (acc_rd_en[b]) begin
            if (b == 2 && rd2 < 0) rd2 = cyc;
            pend = b;
            if (head[b] < 16) head[b]++;
            acc_o_data[b] = {4{$urandom()}};
          end
      end
      if (stalled && (!mem_req || mem_addr !== pa || mem_wdata !== pd)) unstable++;
      if (mem_req && req1 == 0) req1 = cyc;
      if (mem_req && done_cyc > 0) bad++;
      if (mem_req && mem_ready) begin
        if (exp_a.size() == 0) bad++;
        else begin
          if (mem_addr !== exp_a[0] || mem_wdata !== exp_d[0]) bad++;
          void'(exp_a.pop_front());
          void'(exp_d.pop_front());
        end
        beats++;
      end
      stalled = mem_req && !mem_ready;
      pa = mem_addr;
      pd = mem_wdata;
      if (done) begin
        dones++;
        if (done_cyc == 0) done_cyc = cyc;
        if (busy) busy_bad++;
      end
      if (done_cyc > 0 && cyc >= done_cyc + 3) ended = 1;
    end
    start = 1'b0;
    chk($sformatf("t%0d_timeout", id), 64'(ended), 64'd1);
    chk($sformatf("t%0d_beats", id), 64'(beats), 64'(t.exp_beats));
    chk($sformatf("t%0d_pops", id), 64'(pops), 64'(t.exp_pops));
    chk($sformatf("t%0d_addr_data_errs", id), 64'(bad), 64'd0);
    chk($sformatf("t%0d_unstable_stalls", id), 64'(unstable), 64'd0);
    chk($sformatf("t%0d_pop_order_errs", id), 64'(misorder), 64'd0);
    chk($sformatf("t%0d_done_count", id), 64'(dones), 64'd1);
    chk($sformatf("t%0d_busy_with_done", id), 64'(busy_bad), 64'd0);
    chk($sformatf("t%0d_busy_t1", id), 64'(busy1), 64'(t.exp_busy1));
    if (t.exp_rd1 > 0) chk($sformatf("t%0d_first_rd_cycle", id), 64'(rd1), 64'(t.exp_rd1));
    if (t.exp_req1 > 0) chk($sformatf("t%0d_first_req_cycle", id), 64'(req1), 64'(t.exp_req1));
    if (t.exp_busy1 == 0) chk($sformatf("t%0d_zero_done_cycle", id), 64'(done_cyc), 64'd1);
    if (t.stall_buf >= 0) chk($sformatf("t%0d_stall_rd_cycle", id), 64'(rd2), 64'(rel + 1));
  endtask
  initial begin
    bit hit;
    start = 1'b0; base_addr = '0; row_stride = '0; n_rows = '0; n_groups = '0;
    acc_empty = '1; acc_o_data = '0; mem_ready = 1'b0;
    tbl[0] = '{32'h00001000, 32'h40,  2, 4, 100, -1,  0, 1'b0,  32,  8, 1, 2, 4};
    tbl[1] = '{32'h00002000, 32'h100, 3, 3,  50, -1,  0, 1'b0,  36,  9, 1, 2, 4};
    tbl[2] = '{32'h00000000, 32'h80,  1, 4, 100,  2, 25, 1'b0,  16,  4, 1, 2, 4};
    tbl[3] = '{32'hFFFFFFF0, 32'h10,  1, 1, 100, -1,  0, 1'b0,   4,  1, 1, 2, 4};
    tbl[4] = '{32'h00004000, 32'h20,  1, 7, 100, -1,  0, 1'b0,  16,  4, 1, 2, 4};
    tbl[5] = '{32'h0,        32'h0,  16, 2,  70, -1,  0, 1'b1, 128, 32, 1, 2, 4};
    tbl[6] = '{32'h00005000, 32'h40,  0, 3, 100, -1,  0, 1'b0,   0,  0, 0, 0, 0};
    tbl[7] = '{32'h00005000, 32'h40,  2, 0, 100, -1,  0, 1'b0,   0,  0, 0, 0, 0};
    tbl[5].base = $urandom() & 32'hFFFFFFFC;
    tbl[5].stride = $urandom();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_addr_data", {mem_addr, mem_wdata}, 64'd0);
    chk("reset_ctrl", 64'({acc_rd_en, mem_req, busy, done}), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run(i, tbl[i]);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h3000; row_stride = 32'h40; n_rows = 5'd2; n_groups = 3'd2;
    mem_ready = 1'b0; acc_empty = 4'b0000;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      hit = mem_req;
    end
    chk("arst_reached_write", 64'(hit), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_addr_data", {mem_addr, mem_wdata}, 64'd0);
    chk("arst_ctrl", 64'({acc_rd_en, mem_req, busy, done}), 64'd0);
    #1 rst = 1'b0;
    run(8, tbl[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
